// File: rtl/divider.sv
// Iterative restoring divider: one quotient bit per clock on operand magnitudes,
// with sign correction and divide-by-zero handling applied when the result is stored.
module divider #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             div_begin,
   input  logic             div_signed,
   input  logic [WIDTH-1:0] div_op1,
   input  logic [WIDTH-1:0] div_op2,
   output logic             div_busy,
   output logic             div_end,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder
);

   localparam int unsigned CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      count;
   logic               s1, s2, dbz;
   logic [WIDTH-1:0]   abs_b;
   logic [WIDTH-1:0]   raw_a;
   logic [2*WIDTH-1:0] work;

   logic               neg_a, neg_b;
   logic [WIDTH-1:0]   abs_a_in, abs_b_in;
   logic [WIDTH:0]     trial;
   logic [2*WIDTH-1:0] work_next;
   logic [WIDTH-1:0]   q_mag, r_mag;
   logic               last_iter;

   always_comb begin
      neg_a    = div_signed & div_op1[WIDTH-1];
      neg_b    = div_signed & div_op2[WIDTH-1];
      abs_a_in = neg_a ? (~div_op1 + 1'b1) : div_op1;
      abs_b_in = neg_b ? (~div_op2 + 1'b1) : div_op2;
   end

   // Partial remainder after the shift is work[2W-1:W-1]; the bit shifted out of
   // the top half is kept as the 33rd bit of the trial so it is never lost.
   always_comb begin
      trial = work[2*WIDTH-1:WIDTH-1] - {1'b0, abs_b};
      if (!trial[WIDTH])
         work_next = {trial[WIDTH-1:0], work[WIDTH-2:0], 1'b1};
      else
         work_next = {work[2*WIDTH-2:0], 1'b0};
      q_mag     = work_next[WIDTH-1:0];
      r_mag     = work_next[2*WIDTH-1:WIDTH];
      last_iter = (count == CW'(WIDTH - 1));
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (div_begin) state_d = BUSY;
         BUSY:    if (last_iter) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         count     <= '0;
         s1        <= 1'b0;
         s2        <= 1'b0;
         dbz       <= 1'b0;
         abs_b     <= '0;
         raw_a     <= '0;
         work      <= '0;
         quotient  <= '0;
         remainder <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (div_begin) begin
                  s1    <= neg_a;
                  s2    <= neg_b;
                  dbz   <= (div_op2 == '0);
                  abs_b <= abs_b_in;
                  raw_a <= div_op1;
                  work  <= {{WIDTH{1'b0}}, abs_a_in};
                  count <= '0;
               end
            end
            BUSY: begin
               work  <= work_next;
               count <= count + 1'b1;
               if (last_iter) begin
                  quotient  <= dbz ? '1    : ((s1 ^ s2) ? (~q_mag + 1'b1) : q_mag);
                  remainder <= dbz ? raw_a : (s1 ? (~r_mag + 1'b1) : r_mag);
               end
            end
            default: ;
         endcase
      end
   end

   assign div_busy = (state_q != IDLE);
   assign div_end  = (state_q == DONE);

endmodule
